// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, selects PC+4 or the ID-stage redirect target,
// and runs the instruction-memory handshake with a not-ready watchdog and halt support.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  input  logic             im_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             im_req,
  output logic             ifid_we,
  output logic             fetch_stall,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state
);

  localparam logic [1:0] StBoot   = 2'd0;
  localparam logic [1:0] StFetch  = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StHalted = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       wait_q, wait_d;
  logic             accept;
  logic             waiting;
  logic             timeout;

  always_comb begin
    im_req  = (state_q == StFetch) || (state_q == StWait);
    waiting = im_req & ~im_ready;
    accept  = im_req & im_ready & ~stall;

    // Not-ready run length counts regardless of stall; any other cycle breaks the run.
    wait_d  = waiting ? wait_q + 8'd1 : 8'd0;
    timeout = waiting && (wait_d == 8'(TIMEOUT));

    pc4     = pc_q + 32'd4;
    pc_d    = accept ? (redirect ? redirect_pc : pc4) : pc_q;
    cnt_d   = accept ? cnt_q + CNT_W'(1) : cnt_q;
    err_d   = err_q | timeout;

    state_d = state_q;
    case (state_q)
      StBoot: state_d = StFetch;
      StFetch, StWait: begin
        // Halt wins over accept for the next state, but an accepted fetch still completes.
        if ((halt && !stall) || timeout) begin
          state_d = StHalted;
        end else if (accept) begin
          state_d = StFetch;
        end else if (waiting) begin
          state_d = StWait;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign ifid_we     = accept;
  assign fetch_stall = waiting;
  assign pc          = pc_q;
  assign fetch_count = cnt_q;
  assign fetch_err   = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected values are queued as each step is driven and
// popped when the corresponding DUT output is sampled.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, halt, im_ready;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc4;
  logic        im_req, ifid_we, fetch_stall, fetch_err;
  logic [31:0] fetch_count;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC (32'h0000_3000),
    .TIMEOUT  (16),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .im_ready    (im_ready),
    .pc          (pc),
    .pc4         (pc4),
    .im_req      (im_req),
    .ifid_we     (ifid_we),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count),
    .state       (state)
  );

  task automatic exp_push(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_out(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // Apply inputs at the falling edge, then settle so outputs reflect them.
  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic h, input logic rdy);
    @(negedge clk);
    reset       = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = h;
    im_ready    = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    exp_push(tag, exp);
    check_out(obs);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    im_ready = 1'b1;
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", 64'(pc), 64'h3000);
    chk("rst_cnt", 64'(fetch_count), 64'd0);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_outs", {61'd0, im_req, ifid_we, fetch_stall}, 64'd0);

    // Zero-wait fetch sequence.
    drive(0, 0, 0, 0, 0, 1);
    chk("boot_state", 64'(state), 64'd0);
    chk("boot_imreq", 64'(im_req), 64'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("f1_pc", 64'(pc), 64'h3000);
    chk("f1_we", 64'(ifid_we), 64'd1);
    chk("f1_pc4", 64'(pc4), 64'h3004);
    drive(0, 0, 0, 0, 0, 1);
    chk("f2_pc", 64'(pc), 64'h3004);
    // Redirect with delay slot at 0x3008.
    drive(0, 0, 1, 32'h3100, 0, 1);
    chk("f3_pc", 64'(pc), 64'h3008);
    chk("slot_we", 64'(ifid_we), 64'd1);

    // Stall with a pending redirect.
    drive(0, 1, 1, 32'h4000, 0, 1);
    chk("redir_pc", 64'(pc), 64'h3100);
    chk("cnt3", 64'(fetch_count), 64'd3);
    chk("stall1_we", 64'(ifid_we), 64'd0);
    drive(0, 1, 1, 32'h4000, 0, 1);
    chk("stall2_pc", 64'(pc), 64'h3100);
    chk("stall2_we", 64'(ifid_we), 64'd0);
    drive(0, 0, 1, 32'h4000, 0, 1);
    chk("unstall_we", 64'(ifid_we), 64'd1);
    drive(0, 0, 1, 32'h300C, 0, 1);
    chk("post_stall_pc", 64'(pc), 64'h4000);
    chk("cnt4", 64'(fetch_count), 64'd4);

    // Three-cycle IM wait at 0x300C; a redirect during the wait must be ignored.
    drive(0, 0, 0, 0, 0, 0);
    chk("w1_pc", 64'(pc), 64'h300C);
    chk("w1_fs", 64'(fetch_stall), 64'd1);
    chk("w1_we", 64'(ifid_we), 64'd0);
    drive(0, 0, 1, 32'hDEAD_0000, 0, 0);
    chk("w2_state", 64'(state), 64'd2);
    chk("w2_fs", 64'(fetch_stall), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    chk("w3_state", 64'(state), 64'd2);
    chk("w3_pc", 64'(pc), 64'h300C);
    chk("w3_fs", 64'(fetch_stall), 64'd1);
    drive(0, 0, 0, 0, 0, 1);
    chk("w4_we", 64'(ifid_we), 64'd1);
    chk("w4_fs", 64'(fetch_stall), 64'd0);
    drive(0, 0, 1, 32'h3020, 0, 1);
    chk("w_done_pc", 64'(pc), 64'h3010);
    chk("w_done_state", 64'(state), 64'd1);
    chk("cnt6", 64'(fetch_count), 64'd6);

    // Halt together with an accept at 0x3020.
    drive(0, 0, 0, 0, 1, 1);
    chk("halt_pc", 64'(pc), 64'h3020);
    chk("halt_we", 64'(ifid_we), 64'd1);
    drive(0, 0, 1, 32'h5000, 0, 1);
    chk("halted_state", 64'(state), 64'd3);
    chk("halted_pc", 64'(pc), 64'h3024);
    chk("halted_outs", {61'd0, im_req, ifid_we, fetch_stall}, 64'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("halted_hold_pc", 64'(pc), 64'h3024);
    chk("halted_cnt", 64'(fetch_count), 64'd8);

    // Reset out of HALTED, then hold im_ready low until the watchdog trips.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst2_state", 64'(state), 64'd0);
    chk("rst2_pc", 64'(pc), 64'h3000);
    chk("boot_nostall", 64'(fetch_stall), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      // A stall in the middle of the run must not reset the watchdog count.
      drive(0, (i == 5 || i == 6), 0, 0, 0, 0);
      chk($sformatf("wd_state_%0d", i), 64'(state), (i == 1) ? 64'd1 : 64'd2);
      chk($sformatf("wd_fs_%0d", i), 64'(fetch_stall), 64'd1);
      chk($sformatf("wd_err_%0d", i), 64'(fetch_err), 64'd0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("wd_halted", 64'(state), 64'd3);
    chk("wd_err", 64'(fetch_err), 64'd1);
    chk("wd_imreq", 64'(im_req), 64'd0);
    chk("wd_pc", 64'(pc), 64'h3000);
    drive(0, 0, 0, 0, 0, 1);
    chk("wd_sticky", 64'(fetch_err), 64'd1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst3_err", 64'(fetch_err), 64'd0);
    chk("rst3_pc", 64'(pc), 64'h3000);
    chk("rst3_state", 64'(state), 64'd0);
    chk("rst3_cnt", 64'(fetch_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
